// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and elaboration helpers for the serial adder.
//               Holds the FSM state encoding and the functions that derive
//               the digit count (STEPS) and the digit counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of clocks needed to walk all digits of the operands.
  function automatic int calc_steps(input int width, input int digit);
    return (digit > 0) ? (width / digit) : 1;
  endfunction

  // Counter width for STEPS values; never narrower than one bit so a
  // single-step configuration still has a legal counter.
  function automatic int calc_cnt_w(input int steps);
    int w;
    w = $clog2(steps);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_cell
// Description : Single-bit full adder cell used to build the ripple chain.
// Ports       : a, b  - addend bits
//               ci    - carry in
//               s     - sum bit  (a ^ b ^ ci)
//               co    - carry out ((a & b) | ((a ^ b) & ci))
// Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (w_p & ci);

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle adder computing a + b + cin over WIDTH bits,
//               DIGIT bits per clock through a ripple chain of fa_cell.
//               Produces sum, carry-out and signed overflow with a
//               start / busy / done handshake. All outputs are registered.
// Ports       : clk    - clock, rising edge active
//               rst_n  - asynchronous active-low reset
//               start  - request, accepted when busy = 0
//               a, b   - WIDTH-bit operands, captured on accepted start
//               cin    - carry in, captured on accepted start
//               busy   - high while digits are being added
//               done   - one-cycle pulse when the result is valid
//               sum    - WIDTH-bit result, held until the next completion
//               cout   - carry out of bit WIDTH-1
//               ovf    - two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                 c_STEPS = calc_steps(WIDTH, DIGIT);
  localparam int                 c_CNT_W = calc_cnt_w(c_STEPS);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_STEPS - 1);

  generate
    if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;

  logic [DIGIT:0]     w_c;
  logic [DIGIT-1:0]   w_s;
  logic [WIDTH-1:0]   w_a_next;

  // Ripple chain over the low DIGIT bits of the operand shift registers.
  assign w_c[0] = r_carry;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_chain
      fa_cell u_fa (
        .a  (r_a[i]),
        .b  (r_b[i]),
        .ci (w_c[i]),
        .s  (w_s[i]),
        .co (w_c[i+1])
      );
    end
  endgenerate

  // Operand A doubles as the sum accumulator: each right shift frees DIGIT
  // bits at the top that are refilled with the freshly computed result bits.
  // After STEPS shifts the register holds the complete sum, LSB digit lowest.
  generate
    if (DIGIT == WIDTH) begin : g_acc_full
      assign w_a_next = w_s;
    end else begin : g_acc_shift
      assign w_a_next = {w_s, r_a[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end

        RUN: begin
          r_a     <= w_a_next;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_c[DIGIT];
          r_cnt   <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_LAST) begin
            // Carry into the MSB is the carry entering the top cell of the
            // final digit; carry out of the MSB leaves that same cell.
            sum     <= w_a_next;
            cout    <= w_c[DIGIT];
            ovf     <= w_c[DIGIT] ^ w_c[DIGIT-1];
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. Two instances are used:
//               WIDTH=8/DIGIT=1 and WIDTH=8/DIGIT=4. Expected results are
//               queued when a start is driven and compared on each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       st1, cin1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, sum1;
  logic       st4, cin4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, sum4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] t;
    exp_t       e;
    t    = {1'b0, x} + {1'b0, y} + {8'd0, c};
    e.s  = t[7:0];
    e.co = t[8];
    e.ov = (x[7] == y[7]) && (t[7] != x[7]);
    return e;
  endfunction

  // Drive one accepted start; returns the cycle stamp of the accepting edge.
  task automatic go1(input logic [7:0] x, input logic [7:0] y, input logic c, output int t0);
    @(negedge clk);
    a1 = x; b1 = y; cin1 = c; st1 = 1'b1;
    q1.push_back(model(x, y, c));
    @(posedge clk); #1;
    st1 = 1'b0;
    t0  = cyc;
  endtask

  task automatic go4(input logic [7:0] x, input logic [7:0] y, input logic c, output int t0);
    @(negedge clk);
    a4 = x; b4 = y; cin4 = c; st4 = 1'b1;
    q4.push_back(model(x, y, c));
    @(posedge clk); #1;
    st4 = 1'b0;
    t0  = cyc;
  endtask

  // Bounded waits for done; ok=0 means the bound expired.
  task automatic wait1(output int t, output bit ok);
    ok = 1'b0; t = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done1) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic wait4(output int t, output bit ok);
    ok = 1'b0; t = cyc;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done4) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    st1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    st4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut1: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy1, done1, sum1, cout1, ovf1);
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 12'h000) begin
      failures++;
      $display("FAIL reset_dut4: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
               busy4, done4, sum4, cout4, ovf4);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_digit1;
    logic [16:0] tbl [3];
    int   t0, t;
    bit   ok;
    exp_t e;
    tbl[0] = {8'hFF, 8'h01, 1'b0};
    tbl[1] = {8'h7F, 8'h01, 1'b0};
    tbl[2] = {8'h80, 8'h80, 1'b0};
    for (int k = 0; k < 7; k++) begin
      if (k < 3) go1(tbl[k][16:9], tbl[k][8:1], tbl[k][0], t0);
      else       go1(8'($urandom), 8'($urandom), 1'($urandom), t0);
      wait1(t, ok);
      e = q1.pop_front();
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL d1_timeout[%0d]: no done within bound", k);
      end else begin
        checks += 3;
        if (t - t0 !== 8) begin
          failures++;
          $display("FAIL d1_latency[%0d]: got %0d expected 8", k, t - t0);
        end
        if (sum1 !== e.s) begin
          failures++;
          $display("FAIL d1_sum[%0d]: got %h expected %h", k, sum1, e.s);
        end
        if ({cout1, ovf1} !== {e.co, e.ov}) begin
          failures++;
          $display("FAIL d1_flags[%0d]: got cout=%b ovf=%b expected cout=%b ovf=%b",
                   k, cout1, ovf1, e.co, e.ov);
        end
      end
    end
  endtask

  task automatic test_digit4;
    int   t0, t;
    bit   ok;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) go4(8'hA5, 8'h5A, 1'b1, t0);
      else        go4(8'($urandom), 8'($urandom), 1'($urandom), t0);
      wait4(t, ok);
      e = q4.pop_front();
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL d4_timeout[%0d]: no done within bound", k);
      end else begin
        checks += 3;
        if (t - t0 !== 2) begin
          failures++;
          $display("FAIL d4_latency[%0d]: got %0d expected 2", k, t - t0);
        end
        if (sum4 !== e.s) begin
          failures++;
          $display("FAIL d4_sum[%0d]: got %h expected %h", k, sum4, e.s);
        end
        if ({cout4, ovf4} !== {e.co, e.ov}) begin
          failures++;
          $display("FAIL d4_flags[%0d]: got cout=%b ovf=%b expected cout=%b ovf=%b",
                   k, cout4, ovf4, e.co, e.ov);
        end
      end
    end
  endtask

  task automatic test_busy_ignored;
    int   t0, t, extra;
    bit   ok;
    exp_t e;
    go1(8'h10, 8'h20, 1'b0, t0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a1 = 8'hFF; b1 = 8'hFF; st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    checks++;
    if ({busy1, done1} !== 2'b10) begin
      failures++;
      $display("FAIL busy_mid: got busy=%b done=%b expected busy=1 done=0", busy1, done1);
    end
    wait1(t, ok);
    e = q1.pop_front();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL busy_timeout: no done within bound");
    end else begin
      checks += 2;
      if (t - t0 !== 8) begin
        failures++;
        $display("FAIL busy_latency: got %0d expected 8", t - t0);
      end
      if (sum1 !== e.s) begin
        failures++;
        $display("FAIL busy_sum: got %h expected %h", sum1, e.s);
      end
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++;
      $display("FAIL busy_second_run: got %0d busy/done cycles expected 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int   t0, t;
    bit   ok;
    exp_t e;
    go1(8'h05, 8'h06, 1'b0, t0);
    wait1(t, ok);
    e = q1.pop_front();
    checks++;
    if (!ok || sum1 !== e.s) begin
      failures++;
      $display("FAIL b2b_first: got ok=%b sum=%h expected ok=1 sum=%h", ok, sum1, e.s);
    end
    // Still inside the done cycle: this start must be accepted.
    go1(8'h01, 8'h02, 1'b0, t0);
    checks++;
    if ({busy1, done1, sum1} !== {1'b1, 1'b0, 8'h0B}) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b done=%b sum=%h expected busy=1 done=0 sum=0b",
               busy1, done1, sum1);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sum1 !== 8'h0B) begin
      failures++;
      $display("FAIL b2b_hold: got sum=%h expected 0b", sum1);
    end
    wait1(t, ok);
    e = q1.pop_front();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_timeout: no done within bound");
    end else begin
      checks += 2;
      if (t - t0 !== 8) begin
        failures++;
        $display("FAIL b2b_latency: got %0d expected 8", t - t0);
      end
      if (sum1 !== e.s) begin
        failures++;
        $display("FAIL b2b_sum: got %h expected %h", sum1, e.s);
      end
    end
  endtask

  task automatic test_reset_mid;
    int   t0, t, seen;
    bit   ok;
    exp_t e;
    go1(8'h33, 8'h44, 1'b0, t0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy: got %b expected 1", busy1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== 12'h000) begin
      failures++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy1, done1, sum1, cout1, ovf1);
    end
    checks++;
    if ({busy4, done4, sum4, cout4, ovf4} !== 12'h000) begin
      failures++;
      $display("FAIL rst_mid_outputs4: got busy=%b done=%b sum=%h expected all 0",
               busy4, done4, sum4);
    end
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_mid_ghost: got %0d busy/done cycles expected 0", seen);
    end
    go1(8'h12, 8'h34, 1'b1, t0);
    wait1(t, ok);
    e = q1.pop_front();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_mid_restart_timeout: no done within bound");
    end else begin
      checks += 2;
      if (t - t0 !== 8) begin
        failures++;
        $display("FAIL rst_mid_restart_latency: got %0d expected 8", t - t0);
      end
      if ({sum1, cout1, ovf1} !== {e.s, e.co, e.ov}) begin
        failures++;
        $display("FAIL rst_mid_restart_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 sum1, cout1, ovf1, e.s, e.co, e.ov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digit1();
    test_digit4();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
